// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-bus signal bundle for mem_port_arbiter.
// The slave modport is the arbiter's view; master is the core/bus side.
interface mem_port_arbiter_if;
  logic        io_imem_req_valid;
  logic        io_imem_req_ready;
  logic [31:0] io_imem_addr;
  logic        io_imem_resp_valid;
  logic [31:0] io_imem_resp_rdata;
  logic        io_imem_resp_err;

  logic        io_dmem_req_valid;
  logic        io_dmem_req_ready;
  logic [31:0] io_dmem_addr;
  logic        io_dmem_wen;
  logic [3:0]  io_dmem_mask;
  logic [31:0] io_dmem_wdata;
  logic        io_dmem_resp_valid;
  logic [31:0] io_dmem_resp_rdata;
  logic        io_dmem_resp_err;

  logic        io_bus_req;
  logic        io_bus_gnt;
  logic [31:0] io_bus_addr;
  logic        io_bus_wen;
  logic [3:0]  io_bus_mask;
  logic [31:0] io_bus_wdata;
  logic        io_bus_rvalid;
  logic [31:0] io_bus_rdata;

  logic        io_busy;

  modport slave (
    input  io_imem_req_valid, io_imem_addr,
    output io_imem_req_ready, io_imem_resp_valid, io_imem_resp_rdata, io_imem_resp_err,
    input  io_dmem_req_valid, io_dmem_addr, io_dmem_wen, io_dmem_mask, io_dmem_wdata,
    output io_dmem_req_ready, io_dmem_resp_valid, io_dmem_resp_rdata, io_dmem_resp_err,
    output io_bus_req, io_bus_addr, io_bus_wen, io_bus_mask, io_bus_wdata,
    input  io_bus_gnt, io_bus_rvalid, io_bus_rdata,
    output io_busy
  );

  modport master (
    output io_imem_req_valid, io_imem_addr,
    input  io_imem_req_ready, io_imem_resp_valid, io_imem_resp_rdata, io_imem_resp_err,
    output io_dmem_req_valid, io_dmem_addr, io_dmem_wen, io_dmem_mask, io_dmem_wdata,
    input  io_dmem_req_ready, io_dmem_resp_valid, io_dmem_resp_rdata, io_dmem_resp_err,
    input  io_bus_req, io_bus_addr, io_bus_wen, io_bus_mask, io_bus_wdata,
    output io_bus_gnt, io_bus_rvalid, io_bus_rdata,
    input  io_busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory bus between instruction
// fetch and data access, one transaction outstanding, with bus timeout.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES  = 256,
  parameter bit          RESET_LAST_IMEM = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave io
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_t;

  localparam logic        OWN_IMEM   = 1'b0;
  localparam logic        OWN_DMEM   = 1'b1;
  localparam logic        RESET_LAST = RESET_LAST_IMEM ? OWN_IMEM : OWN_DMEM;
  localparam bit          TO_EN      = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TO_LAST    = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic        r_owner;
  logic        r_last;
  logic [31:0] r_addr;
  logic        r_wen;
  logic [3:0]  r_mask;
  logic [31:0] r_wdata;
  logic [15:0] r_cnt;
  logic        r_bus_req;

  logic        r_imem_rvalid;
  logic [31:0] r_imem_rdata;
  logic        r_imem_err;
  logic        r_dmem_rvalid;
  logic [31:0] r_dmem_rdata;
  logic        r_dmem_err;

  logic        w_idle;
  logic        w_imem_ready;
  logic        w_dmem_ready;
  logic        w_accept;
  logic        w_expire;
  logic        w_done_ok;
  logic        w_done_to;
  logic        w_fire;
  logic [31:0] w_rdata;

  // On a tie the requester that was not served last wins.
  assign w_idle       = (r_state == ST_IDLE);
  assign w_imem_ready = w_idle && io.io_imem_req_valid &&
                        (!io.io_dmem_req_valid || (r_last == OWN_DMEM));
  assign w_dmem_ready = w_idle && io.io_dmem_req_valid &&
                        (!io.io_imem_req_valid || (r_last == OWN_IMEM));
  assign w_accept     = w_imem_ready || w_dmem_ready;

  // A gnt/rvalid arriving in the last allowed cycle beats the timeout.
  assign w_expire  = TO_EN && (r_cnt == TO_LAST);
  assign w_done_ok = (r_state == ST_RESP) && io.io_bus_rvalid;
  assign w_done_to = w_expire &&
                     (((r_state == ST_REQ)  && !io.io_bus_gnt) ||
                      ((r_state == ST_RESP) && !io.io_bus_rvalid));
  assign w_fire    = w_done_ok || w_done_to;
  assign w_rdata   = (w_done_ok && !r_wen) ? io.io_bus_rdata : 32'h0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_owner       <= OWN_IMEM;
      r_last        <= RESET_LAST;
      r_addr        <= 32'h0;
      r_wen         <= 1'b0;
      r_mask        <= 4'h0;
      r_wdata       <= 32'h0;
      r_cnt         <= 16'h0;
      r_bus_req     <= 1'b0;
      r_imem_rvalid <= 1'b0;
      r_imem_rdata  <= 32'h0;
      r_imem_err    <= 1'b0;
      r_dmem_rvalid <= 1'b0;
      r_dmem_rdata  <= 32'h0;
      r_dmem_err    <= 1'b0;
    end else begin
      r_imem_rvalid <= 1'b0;
      r_dmem_rvalid <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_owner   <= w_dmem_ready;
            r_last    <= w_dmem_ready;
            r_cnt     <= 16'h0;
            r_bus_req <= 1'b1;
            r_state   <= ST_REQ;
            if (w_dmem_ready) begin
              r_addr  <= io.io_dmem_addr;
              r_wen   <= io.io_dmem_wen;
              r_mask  <= io.io_dmem_mask;
              r_wdata <= io.io_dmem_wdata;
            end else begin
              r_addr  <= io.io_imem_addr;
              r_wen   <= 1'b0;
              r_mask  <= 4'hF;
              r_wdata <= 32'h0;
            end
          end
        end
        ST_REQ: begin
          r_cnt <= r_cnt + 16'd1;
          if (io.io_bus_gnt) begin
            r_bus_req <= 1'b0;
            r_state   <= ST_RESP;
          end else if (w_done_to) begin
            r_bus_req <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        ST_RESP: begin
          r_cnt <= r_cnt + 16'd1;
          if (w_fire) r_state <= ST_IDLE;
        end
        default: begin
          r_bus_req <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase

      if (w_fire) begin
        if (r_owner == OWN_DMEM) begin
          r_dmem_rvalid <= 1'b1;
          r_dmem_rdata  <= w_rdata;
          r_dmem_err    <= w_done_to;
        end else begin
          r_imem_rvalid <= 1'b1;
          r_imem_rdata  <= w_rdata;
          r_imem_err    <= w_done_to;
        end
      end
    end
  end

  assign io.io_imem_req_ready  = w_imem_ready;
  assign io.io_dmem_req_ready  = w_dmem_ready;
  assign io.io_imem_resp_valid = r_imem_rvalid;
  assign io.io_imem_resp_rdata = r_imem_rdata;
  assign io.io_imem_resp_err   = r_imem_err;
  assign io.io_dmem_resp_valid = r_dmem_rvalid;
  assign io.io_dmem_resp_rdata = r_dmem_rdata;
  assign io.io_dmem_resp_err   = r_dmem_err;
  assign io.io_bus_req         = r_bus_req;
  assign io.io_bus_addr        = r_addr;
  assign io.io_bus_wen         = r_wen;
  assign io.io_bus_mask        = r_mask;
  assign io.io_bus_wdata       = r_wdata;
  assign io.io_busy            = !w_idle;

endmodule
